// File: rtl/nand_gate_array_if.sv
// Operand/result stream bundle for nand_gate_array.
// The master drives operands and result-ready. The slave (the unit) drives
// operand-ready and the result.
interface nand_gate_array_if #(
  parameter int WIDTH = 8
) ();
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output op, a, b, in_valid, out_ready,
    input  in_ready, y, out_valid
  );

  modport slave (
    input  op, a, b, in_valid, out_ready,
    output in_ready, y, out_valid
  );
endinterface

// File: rtl/nand_gate_array.sv
// Pipelined WIDTH-lane logic unit. Every function is composed only of 2-input
// NAND. A built-in sweep engine injects all 32 op/input combinations and
// reports how many produced y[0]=1, and whether any lanes disagreed.
module nand_gate_array #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  nand_gate_array_if.slave    bus,
  input  logic                sweep_start,
  output logic                sweep_busy,
  output logic                sweep_done,
  output logic [5:0]          sweep_ones,
  output logic                sweep_err
);

  localparam int LAST = STAGES - 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Basic cell: everything else is built from this.
  function automatic logic [WIDTH-1:0] nand2(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] z);
    return ~(x & z);
  endfunction

  // Eight ops expressed as NAND networks; NOT/BUF ignore b.
  function automatic logic [WIDTH-1:0] logic_op(input logic [2:0]       sel,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] z);
    logic [WIDTH-1:0] n_xz;
    logic [WIDTH-1:0] n_x;
    logic [WIDTH-1:0] n_z;
    logic [WIDTH-1:0] or_v;
    logic [WIDTH-1:0] xor_v;
    logic [WIDTH-1:0] r;
    n_xz  = nand2(x, z);
    n_x   = nand2(x, x);
    n_z   = nand2(z, z);
    or_v  = nand2(n_x, n_z);
    xor_v = nand2(nand2(x, n_xz), nand2(z, n_xz));
    case (sel)
      3'd0:    r = n_xz;
      3'd1:    r = nand2(n_xz, n_xz);
      3'd2:    r = or_v;
      3'd3:    r = nand2(or_v, or_v);
      3'd4:    r = xor_v;
      3'd5:    r = nand2(xor_v, xor_v);
      3'd6:    r = n_x;
      default: r = nand2(n_x, n_x);
    endcase
    return r;
  endfunction

  // One-count accumulator stops at 32 (the number of sweep beats).
  function automatic logic [5:0] sat_inc(input logic [5:0] c, input logic inc);
    if (inc && (c < 6'd32)) begin
      return c + 6'd1;
    end
    return c;
  endfunction

  // A lane disagreement shows as a result that is neither all-0 nor all-1.
  function automatic logic lanes_mixed(input logic [WIDTH-1:0] v);
    return (v != '0) && (v != '1);
  endfunction

  state_t           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [5:0]       ones_q, ones_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] dat_q [STAGES];
  logic [WIDTH-1:0] dat_d [STAGES];
  logic             vld_q [STAGES];
  logic             vld_d [STAGES];
  logic             swp_q [STAGES];
  logic             swp_d [STAGES];

  logic             fsm_idle, fsm_wait, fsm_run, fsm_force;
  logic             en, in_ready_w, out_valid_w;
  logic             any_vld, inner_swp, swp_out;
  logic [2:0]       s0_op;
  logic [WIDTH-1:0] s0_a, s0_b;
  logic             s0_vld;

  // Pipe status summaries used by the FSM.
  always_comb begin
    any_vld   = 1'b0;
    inner_swp = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      any_vld = any_vld | vld_q[i];
      if (i < LAST) begin
        inner_swp = inner_swp | (vld_q[i] & swp_q[i]);
      end
    end
  end

  // Sweep FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Sweep FSM next-state logic; sweep_start outside IDLE is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (sweep_start) state_d = S_WAIT;
      S_WAIT:  if (!any_vld) state_d = S_RUN;
      S_RUN:   if (cnt_q == 5'd31) state_d = S_DRAIN;
      S_DRAIN: if (!inner_swp) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sweep FSM outputs decoded from the current state.
  always_comb begin
    fsm_idle   = (state_q == S_IDLE);
    fsm_wait   = (state_q == S_WAIT);
    fsm_run    = (state_q == S_RUN);
    fsm_force  = (state_q == S_RUN) || (state_q == S_DRAIN);
    sweep_busy = (state_q == S_WAIT) || (state_q == S_RUN) || (state_q == S_DRAIN);
    sweep_done = (state_q == S_DONE);
  end

  // Handshake: all stages advance together; during RUN/DRAIN the pipe is
  // free-running and the external consumer is not consulted.
  always_comb begin
    out_valid_w = vld_q[LAST] & ~swp_q[LAST];
    en          = fsm_force | ~out_valid_w | bus.out_ready;
    in_ready_w  = rst_n & fsm_idle & en;
    swp_out     = vld_q[LAST] & swp_q[LAST];
  end

  // Stage-0 source: external operands normally, counter-derived in RUN.
  always_comb begin
    if (fsm_run) begin
      s0_op  = cnt_q[4:2];
      s0_a   = {WIDTH{cnt_q[0]}};
      s0_b   = {WIDTH{cnt_q[1]}};
      s0_vld = 1'b1;
    end else begin
      s0_op  = bus.op;
      s0_a   = bus.a;
      s0_b   = bus.b;
      s0_vld = bus.in_valid & in_ready_w;
    end
  end

  // Next pipe contents: shift on en, otherwise hold every stage.
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      dat_d[i] = dat_q[i];
      vld_d[i] = vld_q[i];
      swp_d[i] = swp_q[i];
    end
    if (en) begin
      dat_d[0] = logic_op(s0_op, s0_a, s0_b);
      vld_d[0] = s0_vld;
      swp_d[0] = fsm_run;
      for (int i = 1; i < STAGES; i++) begin
        dat_d[i] = dat_q[i-1];
        vld_d[i] = vld_q[i-1];
        swp_d[i] = swp_q[i-1];
      end
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        dat_q[i] <= '0;
        vld_q[i] <= 1'b0;
        swp_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        dat_q[i] <= dat_d[i];
        vld_q[i] <= vld_d[i];
        swp_q[i] <= swp_d[i];
      end
    end
  end

  // Sweep counter advances only while injecting, parked at 0 otherwise.
  always_comb begin
    cnt_d = fsm_run ? (cnt_q + 5'd1) : 5'd0;
  end

  // Sweep statistics: cleared in WAIT, accumulated as sweep beats exit.
  always_comb begin
    ones_d = ones_q;
    err_d  = err_q;
    if (fsm_wait) begin
      ones_d = 6'd0;
      err_d  = 1'b0;
    end else if (swp_out) begin
      ones_d = sat_inc(ones_q, dat_q[LAST][0]);
      err_d  = err_q | lanes_mixed(dat_q[LAST]);
    end
  end

  // Sweep counter and statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 5'd0;
      ones_q <= 6'd0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      ones_q <= ones_d;
      err_q  <= err_d;
    end
  end

  assign bus.y         = dat_q[LAST];
  assign bus.out_valid = out_valid_w;
  assign bus.in_ready  = in_ready_w;
  assign sweep_ones    = ones_q;
  assign sweep_err     = err_q;

endmodule

// File: tb/tb_nand_gate_array.sv
// Bench for nand_gate_array: directed cases plus randomized traffic, checked
// against a queue-based reference model of the stream and sweep behaviour.
module tb_nand_gate_array;
  localparam int WIDTH  = 8;
  localparam int STAGES = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sweep_start;
  logic       sweep_busy, sweep_done, sweep_err;
  logic [5:0] sweep_ones;

  always #5 clk = ~clk;

  nand_gate_array_if #(.WIDTH(WIDTH)) bus ();

  nand_gate_array #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .sweep_start(sweep_start),
    .sweep_busy (sweep_busy),
    .sweep_done (sweep_done),
    .sweep_ones (sweep_ones),
    .sweep_err  (sweep_err)
  );

  typedef struct {
    logic [WIDTH-1:0] y;
    int               cyc;
  } exp_t;

  exp_t             sb[$];
  int               n_chk = 0;
  int               n_err = 0;
  int               cyc = 0;
  int               done_cnt = 0;
  bit               lat_chk = 1'b0;
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_y = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference behaviour of one op, plain bitwise operators.
  function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] o,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] z);
    case (o)
      3'd0:    return ~(x & z);
      3'd1:    return x & z;
      3'd2:    return x | z;
      3'd3:    return ~(x | z);
      3'd4:    return x ^ z;
      3'd5:    return ~(x ^ z);
      3'd6:    return ~x;
      default: return x;
    endcase
  endfunction

  // Expected sweep_ones: y[0] summed over all 32 op/input combinations.
  function automatic int sweep_ref();
    int               ones;
    logic [WIDTH-1:0] r;
    ones = 0;
    for (int c = 0; c < 32; c++) begin
      r = ref_op(3'(c >> 2), {WIDTH{c[0]}}, {WIDTH{c[1]}});
      ones += int'(r[0]);
    end
    return ones;
  endfunction

  // One clock: drive at negedge, sample #1 later, score the coming edge.
  task automatic cycle(input logic iv, input logic [2:0] o,
                       input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                       input logic ordy, input logic sst, output bit acc);
    exp_t e;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.op        = o;
    bus.a         = aa;
    bus.b         = bb;
    bus.out_ready = ordy;
    sweep_start   = sst;
    #1;
    cyc++;
    acc = 1'b0;
    if (rst_n) begin
      chk("in_ready_rule", 64'(bus.in_ready),
          64'((!bus.out_valid || bus.out_ready) && !sweep_busy && !sweep_done));
      if (prev_stall) begin
        chk("hold_valid", 64'(bus.out_valid), 64'(1));
        chk("hold_y", 64'(bus.y), 64'(prev_y));
      end
      if (sweep_busy && !prev_stall) chk("sweep_out_valid", 64'(bus.out_valid), 64'(0));
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          chk("y", 64'(bus.y), 64'(e.y));
          if (lat_chk) chk("latency", 64'(cyc - e.cyc), 64'(STAGES));
        end
      end
      if (iv && bus.in_ready) begin
        sb.push_back('{ref_op(o, aa, bb), cyc});
        acc = 1'b1;
      end
      if (sweep_done) done_cnt++;
    end
    prev_stall = rst_n && bus.out_valid && !bus.out_ready;
    prev_y     = bus.y;
  endtask

  task automatic idle(input int n, input logic ordy);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, '0, '0, ordy, 1'b0, acc);
  endtask

  // Run a sweep to completion from an already-pulsed start; bounded.
  task automatic finish_sweep(input int d0);
    bit acc;
    for (int i = 0; i < 200 && done_cnt == d0; i++) begin
      cycle(1'b0, 3'd0, '0, '0, 1'b1, (i == 10), acc);
    end
    idle(3, 1'b1);
    chk("sweep_done_pulses", 64'(done_cnt - d0), 64'(1));
    chk("sweep_ones", 64'(sweep_ones), 64'(sweep_ref()));
    chk("sweep_err", 64'(sweep_err), 64'(0));
    chk("sweep_busy_after", 64'(sweep_busy), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit               acc;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a, r_b;
    logic             r_v;
    int               k;
    int               d0;

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
    sweep_start = 1'b0;

    // Reset state
    idle(2, 1'b0);
    chk("rst_y", 64'(bus.y), 64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
    chk("rst_busy", 64'(sweep_busy), 64'(0));
    chk("rst_done", 64'(sweep_done), 64'(0));
    chk("rst_ones", 64'(sweep_ones), 64'(0));
    chk("rst_err", 64'(sweep_err), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    idle(1, 1'b1);
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("post_rst_out_valid", 64'(bus.out_valid), 64'(0));

    // Single NAND beat, latency check
    lat_chk = 1'b1;
    cycle(1'b1, 3'd0, 8'hF0, 8'hCC, 1'b1, 1'b0, acc);
    chk("nand_accept", 64'(acc), 64'(1));
    idle(4, 1'b1);
    chk("drain_single", 64'(sb.size()), 64'(0));

    // All eight ops back-to-back
    for (int o = 0; o < 8; o++) cycle(1'b1, 3'(o), 8'hF0, 8'hCC, 1'b1, 1'b0, acc);
    idle(4, 1'b1);
    chk("drain_ops", 64'(sb.size()), 64'(0));

    // Backpressure: three beats, consumer stalled for several cycles
    lat_chk = 1'b0;
    k = 0;
    for (int i = 0; i < 60 && (k < 3 || sb.size() != 0); i++) begin
      cycle((k < 3), 3'(k + 1), 8'(8'h5A + k), 8'(8'h33 * (k + 1)), (i >= 7), 1'b0, acc);
      if (acc) k++;
    end
    chk("bp_all_accepted", 64'(k), 64'(3));
    chk("bp_drained", 64'(sb.size()), 64'(0));

    // Randomized traffic; operands held until accepted
    r_v = 1'b0; r_op = '0; r_a = '0; r_b = '0; acc = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!r_v || acc) begin
        r_v  = ($urandom_range(0, 3) != 0);
        r_op = 3'($urandom_range(0, 7));
        r_a  = WIDTH'($urandom);
        r_b  = WIDTH'($urandom);
      end
      cycle(r_v, r_op, r_a, r_b, ($urandom_range(0, 3) != 0), 1'b0, acc);
    end
    idle(6, 1'b1);
    chk("rand_drained", 64'(sb.size()), 64'(0));

    // Sweep from idle, with a second start pulse that must be ignored
    d0 = done_cnt;
    cycle(1'b0, 3'd0, '0, '0, 1'b1, 1'b1, acc);
    idle(1, 1'b1);
    chk("sweep_busy_hi", 64'(sweep_busy), 64'(1));
    finish_sweep(d0);

    // Normal traffic resumes after sweep
    lat_chk = 1'b1;
    for (int o = 0; o < 8; o++) cycle(1'b1, 3'(7 - o), 8'hA5, 8'h3C, 1'b1, 1'b0, acc);
    idle(4, 1'b1);
    chk("post_sweep_drained", 64'(sb.size()), 64'(0));
    lat_chk = 1'b0;

    // Sweep requested while a beat is stalled at the output
    cycle(1'b1, 3'd4, 8'h96, 8'h0F, 1'b0, 1'b0, acc);
    idle(2, 1'b0);
    chk("stalled_valid", 64'(bus.out_valid), 64'(1));
    d0 = done_cnt;
    cycle(1'b0, 3'd0, '0, '0, 1'b0, 1'b1, acc);
    idle(4, 1'b0);
    chk("wait_busy", 64'(sweep_busy), 64'(1));
    chk("wait_beat_kept", 64'(bus.out_valid), 64'(1));
    finish_sweep(d0);
    chk("wait_beat_taken", 64'(sb.size()), 64'(0));

    // Reset in the middle of RUN
    cycle(1'b0, 3'd0, '0, '0, 1'b1, 1'b1, acc);
    idle(6, 1'b1);
    chk("mid_run_busy", 64'(sweep_busy), 64'(1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_run_busy", 64'(sweep_busy), 64'(0));
    chk("rst_run_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_run_y", 64'(bus.y), 64'(0));
    chk("rst_run_ones", 64'(sweep_ones), 64'(0));
    sb.delete();
    prev_stall = 1'b0;
    idle(2, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1, 1'b1);
    d0 = done_cnt;
    cycle(1'b0, 3'd0, '0, '0, 1'b1, 1'b1, acc);
    finish_sweep(d0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
